sys_result_drain: RTL and testbench
===================================

// Module: sys_result_drain
// PURPOSE
//  Result-side end of the 4x4 systolic array: captures each PE's accumulated sum (s_out) and saturation
//  flag on its result-write strobe, tracks completion of a run, and serves results and status to the CPU
//  over the ibus read port. Sits beside the array opposite the operand feeder; it is a read-only slave
//  whose read data is daisy-chained, with pass-through of upstream data on a miss.
// PARAMETERS
//  N_PE      16       number of PEs, row-major index i = row*4 + col
//  DW        16       result width per PE
//  BASE_ADR  14'h0C00 ibus word address of result 0; aligned to 32 words (BASE_ADR[4:0]==0)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-high
//  start          in   1        run start pulse from the array controller
//  sw             in   N_PE     per-PE result-write strobe, bit i = PE i
//  s_out_flat     in   N_PE*DW  PE sums, PE i at [i*DW +: DW]
//  sat            in   N_PE     per-PE saturation flag, qualified by sw[i]
//  ibus_ren       in   1        read enable
//  ibus_radr      in   14       read word address [15:2]
//  ibus_rdata_in  in   16       upstream read data (chain input)
//  ibus_rdata     out  16       read data, registered
//  done           out  1        level: all N_PE results captured in current run
//  irq            out  1        completion pulse (RESULT_IRQ_EN only, else constant 0)
// BEHAVIOUR
//  - Reset: state=IDLE, result regs=0, valid=0, satm=0, overrun=0, ibus_rdata=0, done=0, irq=0.
//  - FSM IDLE -> COLLECT on start; COLLECT -> DONE when valid becomes all-ones; DONE -> COLLECT on start.
//    rst in any state returns to IDLE on the next edge; a partial run is discarded.
//  - start (any state): clears valid, satm, overrun next cycle; result regs keep old contents.
//  - COLLECT: for each i with sw[i]=1: res[i]<=s_out_flat slice, valid[i]<=1, satm[i]<=sat[i].
//    Multiple strobes in one cycle all captured. sw[i] when valid[i] already 1: overwrite, overrun<=1 (sticky).
//  - start and sw in the same cycle: start wins, strobes dropped. sw in IDLE or DONE: ignored, no flag.
//  - COLLECT->DONE transition: the cycle after the last valid bit is set; done=1 while state==DONE.
//  - Read map, off = ibus_radr[4:0], hit = ibus_ren & ibus_radr[13:5]==BASE_ADR[13:5] & off<=18:
//      off 0..15 res[off]; 16 valid mask; 17 satm; 18 {13'b0, overrun, state[1:0]} (IDLE=0,COLLECT=1,DONE=2).
//  - Latency 1: ibus_rdata at edge after request = hit ? selected word : ibus_rdata_in (registered).
//    Miss, ibus_ren=0 or off 19..31 -> forward ibus_rdata_in. Read and capture of same reg in one cycle
//    returns pre-capture value.
//  - Reads have no side effects; results stay readable after DONE until overwritten by a later run.
//  - All arithmetic is width-exact; no sign extension, DW==16 so words map 1:1 to ibus_rdata.
// CONFIGURATION
//  RESULT_IRQ_EN defined: irq=1 for exactly one cycle on the COLLECT->DONE transition edge; not re-raised
//    until the next run completes; cleared by rst. Undefined: irq tied 1'b0, no extra flops.
// TESTING
//  1 rst, start, sw[i] pulsed for i=0..15 one per cycle with s_out=16'h0100+i -> done=1 one cycle after
//    i=15; reads off 0..15 return 16'h0100..16'h010F; off16=16'hFFFF; off18=16'h0002.
//  2 start, sw=16'hFFFF in a single cycle with sat=16'h8001 -> done next cycle; off17=16'h8001, overrun=0.
//  3 sw[3] twice (values 16'h1111 then 16'h2222) -> off3=16'h2222, off18 bit2=1; next start clears to 0.
//  4 start and sw=16'h0001 same cycle -> off16=16'h0000; sw outside COLLECT (IDLE) -> no change.
//  5 read miss (radr=BASE_ADR+14'h40) with ibus_rdata_in=16'hBEEF -> ibus_rdata=16'hBEEF one cycle later;
//    off 20 also forwards 16'hBEEF.
//  6 rst asserted mid-run after 8 captures -> off16=0, off18=0, done=0; with RESULT_IRQ_EN, full run gives
//    exactly one irq pulse coincident with done rising.

Source files
------------

// File: rtl/sys_result_drain.sv
// Result-side drain of the 4x4 systolic array: captures PE sums and saturation flags, tracks run
// completion and serves results/status on the daisy-chained ibus read port. Optional: RESULT_IRQ_EN.
module sys_result_drain #(
  parameter int          N_PE     = 16,
  parameter int          DW       = 16,
  parameter logic [13:0] BASE_ADR = 14'h0C00
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [N_PE-1:0]      i_sw,
  input  logic [N_PE*DW-1:0]   i_s_out_flat,
  input  logic [N_PE-1:0]      i_sat,
  input  logic                 i_ibus_ren,
  input  logic [13:0]          i_ibus_radr,
  input  logic [15:0]          i_ibus_rdata_in,
  output logic [15:0]          o_ibus_rdata,
  output logic                 o_done,
  output logic                 o_irq
);

  // state      | meaning
  // ST_IDLE    | after reset, no run started; strobes ignored
  // ST_COLLECT | run in progress, strobes captured
  // ST_DONE    | all N_PE results captured; strobes ignored until next start
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DW-1:0]     r_res [N_PE];
  logic [N_PE-1:0]   r_valid;
  logic [N_PE-1:0]   r_satm;
  logic              r_overrun;
  logic [15:0]       r_rdata;

  logic              w_all_valid;
  logic [N_PE-1:0]   w_cap_mask;
  logic [4:0]        w_off;
  logic              w_hit;
  logic [15:0]       w_rd_sel;

  assign w_all_valid = &r_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        // start restarts the run and takes precedence over completion
        if (i_start)          w_state_nxt = ST_COLLECT;
        else if (w_all_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (i_start) w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cap_mask = ((r_state == ST_COLLECT) && !i_start) ? i_sw : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_valid   <= '0;
      r_satm    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start) begin
        r_valid   <= '0;
        r_satm    <= '0;
        r_overrun <= 1'b0;
      end else begin
        for (int i = 0; i < N_PE; i++) begin
          if (w_cap_mask[i]) begin
            r_valid[i] <= 1'b1;
            r_satm[i]  <= i_sat[i];
          end
        end
        if (|(w_cap_mask & r_valid)) r_overrun <= 1'b1;
      end
    end
  end

  // Result registers survive start so the previous run stays readable until overwritten.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_PE; i++) r_res[i] <= '0;
    end else begin
      for (int i = 0; i < N_PE; i++) begin
        if (w_cap_mask[i]) r_res[i] <= i_s_out_flat[i*DW +: DW];
      end
    end
  end

  assign w_off = i_ibus_radr[4:0];
  assign w_hit = i_ibus_ren && (i_ibus_radr[13:5] == BASE_ADR[13:5]) && (w_off <= 5'd18);

  always_comb begin
    w_rd_sel = 16'h0000;
    if (w_off < 5'd16) begin
      w_rd_sel = r_res[w_off[3:0]];
    end else begin
      case (w_off)
        5'd16:   w_rd_sel = r_valid;
        5'd17:   w_rd_sel = r_satm;
        5'd18:   w_rd_sel = {13'b0, r_overrun, r_state};
        default: w_rd_sel = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rdata <= 16'h0000;
    else       r_rdata <= w_hit ? w_rd_sel : i_ibus_rdata_in;
  end

  assign o_ibus_rdata = r_rdata;
  assign o_done       = (r_state == ST_DONE);

`ifdef RESULT_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_irq <= 1'b0;
    else       r_irq <= (r_state == ST_COLLECT) && (w_state_nxt == ST_DONE);
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sys_result_drain.sv
// Scoreboard bench for sys_result_drain: expected read data queued at request, checked on return.
module tb_sys_result_drain;

  localparam logic [13:0] BASE = 14'h0C00;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   sw;
  logic [255:0]  s_out_flat;
  logic [15:0]   sat;
  logic          ren;
  logic [13:0]   radr;
  logic [15:0]   rdata_in;
  logic [15:0]   rdata;
  logic          done;
  logic          irq;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [15:0]   sb_q[$];
  int            irq_cnt;
  logic          prev_done;
  logic          irq_exp_en;

  sys_result_drain dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_sw            (sw),
    .i_s_out_flat    (s_out_flat),
    .i_sat           (sat),
    .i_ibus_ren      (ren),
    .i_ibus_radr     (radr),
    .i_ibus_rdata_in (rdata_in),
    .o_ibus_rdata    (rdata),
    .o_done          (done),
    .o_irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] base);
    for (int i = 0; i < 16; i++) s_out_flat[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic rd(input string tag, input logic [13:0] adr, input logic [15:0] exp);
    @(negedge clk);
    ren  = 1'b1;
    radr = adr;
    sb_q.push_back(exp);
    tick();
    ren = 1'b0;
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    else                  chk(tag, rdata, sb_q.pop_front());
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
`ifdef RESULT_IRQ_EN
    irq_exp_en = 1'b1;
`else
    irq_exp_en = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; sw = '0; s_out_flat = '0; sat = '0;
    ren = 1'b0; radr = '0; rdata_in = 16'h0000;
    tick(); tick();
    @(negedge clk); rst = 1'b0;
    chk("rst_done", {15'b0, done}, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    rd("rst_stat", BASE + 14'd18, 16'h0000);

    // 1: one strobe per cycle
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sw = 16'h0001 << i;
      set_all(16'h0100);
      for (int k = 0; k < 16; k++) s_out_flat[k*16 +: 16] = 16'h0100 + 16'(i);
      tick();
    end
    chk("t1_done_early", {15'b0, done}, 16'h0000);
    @(negedge clk); sw = '0;
    tick();
    chk("t1_done", {15'b0, done}, 16'h0001);
    chk("t1_irq", {15'b0, irq}, {15'b0, irq_exp_en});
    tick();
    chk("t1_irq_once", {15'b0, irq}, 16'h0000);
    for (int i = 0; i < 16; i++) rd($sformatf("t1_res%0d", i), BASE + 14'(i), 16'h0100 + 16'(i));
    rd("t1_valid", BASE + 14'd16, 16'hFFFF);
    rd("t1_satm", BASE + 14'd17, 16'h0000);
    rd("t1_stat", BASE + 14'd18, 16'h0002);

    // 2: all strobes in one cycle
    pulse_start();
    chk("t2_done_clr", {15'b0, done}, 16'h0000);
    @(negedge clk);
    sw = 16'hFFFF; sat = 16'h8001; set_all(16'hA000);
    tick();
    chk("t2_done_early", {15'b0, done}, 16'h0000);
    @(negedge clk); sw = '0; sat = '0;
    tick();
    chk("t2_done", {15'b0, done}, 16'h0001);
    rd("t2_satm", BASE + 14'd17, 16'h8001);
    rd("t2_stat", BASE + 14'd18, 16'h0002);
    rd("t2_res5", BASE + 14'd5, 16'hA005);

    // 3: overrun
    pulse_start();
    @(negedge clk); sw = 16'h0008; s_out_flat[3*16 +: 16] = 16'h1111;
    tick();
    @(negedge clk); s_out_flat[3*16 +: 16] = 16'h2222;
    tick();
    @(negedge clk); sw = '0;
    rd("t3_res3", BASE + 14'd3, 16'h2222);
    rd("t3_stat", BASE + 14'd18, 16'h0005);
    pulse_start();
    rd("t3_stat_clr", BASE + 14'd18, 16'h0001);
    rd("t3_valid_clr", BASE + 14'd16, 16'h0000);

    // 4: start wins over strobes; strobes ignored in IDLE
    @(negedge clk); start = 1'b1; sw = 16'h0001; s_out_flat[15:0] = 16'h5555;
    tick();
    @(negedge clk); start = 1'b0; sw = '0;
    rd("t4_valid", BASE + 14'd16, 16'h0000);
    rd("t4_res0", BASE + 14'd0, 16'hA000);
    @(negedge clk); rst = 1'b1;
    tick();
    @(negedge clk); rst = 1'b0; sw = 16'hFFFF; set_all(16'h6000);
    tick();
    @(negedge clk); sw = '0;
    rd("t4_idle_valid", BASE + 14'd16, 16'h0000);
    rd("t4_idle_res0", BASE + 14'd0, 16'h0000);
    rd("t4_idle_stat", BASE + 14'd18, 16'h0000);

    // 5: pass-through of upstream data
    rdata_in = 16'hBEEF;
    rd("t5_miss", BASE + 14'h40, 16'hBEEF);
    rd("t5_off20", BASE + 14'd20, 16'hBEEF);
    rd("t5_off19", BASE + 14'd19, 16'hBEEF);
    @(negedge clk); ren = 1'b0; radr = BASE;
    tick();
    chk("t5_noren", rdata, 16'hBEEF);
    rdata_in = 16'h0000;

    // 6: reset mid-run, then full run with irq accounting
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); sw = 16'h0001 << i; set_all(16'h3000);
      tick();
    end
    @(negedge clk); sw = '0; rst = 1'b1;
    tick();
    @(negedge clk); rst = 1'b0;
    chk("t6_done", {15'b0, done}, 16'h0000);
    rd("t6_valid", BASE + 14'd16, 16'h0000);
    rd("t6_stat", BASE + 14'd18, 16'h0000);
    rd("t6_res0", BASE + 14'd0, 16'h0000);
    pulse_start();
    @(negedge clk);
    sw = 16'h0001; s_out_flat[15:0] = 16'h7777; ren = 1'b1; radr = BASE;
    sb_q.push_back(16'h0000);
    tick();
    ren = 1'b0; sw = '0;
    chk("t6_rd_precap", rdata, sb_q.pop_front());
    rd("t6_rd_postcap", BASE + 14'd0, 16'h7777);
    irq_cnt = 0;
    prev_done = done;
    @(negedge clk); sw = 16'hFFFF; set_all(16'h4000);
    tick();
    @(negedge clk); sw = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (irq) irq_cnt++;
      chk($sformatf("t6_irq_c%0d", c), {15'b0, irq}, {15'b0, irq_exp_en & done & ~prev_done});
      prev_done = done;
    end
    chk("t6_irq_cnt", 16'(irq_cnt), {15'b0, irq_exp_en});
    chk("t6_done_full", {15'b0, done}, 16'h0001);
    rd("t6_stat_full", BASE + 14'd18, 16'h0006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
